// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI bus arbiter.
package spi_arb_pkg;

    // Arbiter sequencing: wait for work, fire the master, wait for its done.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_e;

    // Identifies requester 0 or requester 1.
    typedef logic req_id_t;

    localparam int unsigned NUM_REQ  = 2;
    localparam logic [15:0] TMO_DATA = 16'hFFFF;

    // Round-robin pick: on contention the requester that did not go last wins;
    // a lone pending requester is always picked.
    function automatic req_id_t rr_pick(input logic [1:0] pend, input req_id_t last_owner);
        if (pend == 2'b11) begin
            return req_id_t'(~last_owner);
        end else if (pend[0]) begin
            return req_id_t'(1'b0);
        end else begin
            return req_id_t'(1'b1);
        end
    endfunction

endpackage

// File: rtl/spi_arb_tmo_cnt.sv
// BUSY-cycle watchdog for the SPI arbiter. Counts consecutive cycles with
// busy_i high and flags the cycle in which the TMO_CYCLES-th one is reached.
module spi_arb_tmo_cnt #(
    parameter int unsigned TMO_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    output logic expire_o
);

    localparam int unsigned CW = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count while busy, restart from zero whenever the arbiter leaves BUSY.
    always_comb begin
        cnt_d = '0;
        if (busy_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds (BUSY cycles so far - 1), so this fires in the last allowed cycle.
    assign expire_o = busy_i && (cnt_q == CW'(TMO_CYCLES - 1));

endmodule

// File: rtl/spi_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI_mstr16.
// Optional feature macro: SPI_ARB_TIMEOUT_EN (BUSY watchdog, err_tmo flag).
//
// Handshake: req<i> is a one-cycle request carrying cmd<i>; it is accepted
// when requester i has nothing pending or in flight, otherwise it is dropped
// and err_ovr[i] sticks. done<i> is a one-cycle pulse that coincides with the
// new rd_data; the requester may issue its next req in that same cycle.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rd_data,
    output logic        mstr_wrt,
    output logic [15:0] mstr_cmd,
    input  logic        mstr_done,
    input  logic [15:0] mstr_rd,
    input  logic        mstr_ss_n,
    output logic        ss0_n,
    output logic        ss1_n,
    output logic [1:0]  err_ovr,
    output logic        err_tmo
);

    arb_state_e  state_q, state_d;
    logic [1:0]  pend_q, pend_d;
    logic [15:0] cmd_q [NUM_REQ];
    logic [15:0] cmd_d [NUM_REQ];
    req_id_t     owner_q, owner_d;
    req_id_t     last_owner_q, last_owner_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_ovr_q, err_ovr_d;

    logic [1:0]  req_v;
    logic [15:0] cmd_in [NUM_REQ];
    logic        in_busy;

    assign req_v     = {req1, req0};
    assign cmd_in[0] = cmd0;
    assign cmd_in[1] = cmd1;
    assign in_busy   = (state_q == BUSY);

`ifdef SPI_ARB_TIMEOUT_EN
    logic tmo_expire;
    logic tmo_hit;
    logic err_tmo_q;

    spi_arb_tmo_cnt #(
        .TMO_CYCLES(TMO_CYCLES)
    ) u_tmo_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .busy_i  (in_busy),
        .expire_o(tmo_expire)
    );

    // Sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_tmo_q <= 1'b0;
        end else begin
            err_tmo_q <= err_tmo_q | tmo_hit;
        end
    end

    assign err_tmo = err_tmo_q;
`else
    // Without the watchdog BUSY waits forever for mstr_done.
    logic [31:0] tmo_cycles_unused;
    logic        in_busy_unused;
    assign tmo_cycles_unused = 32'(TMO_CYCLES);
    assign in_busy_unused    = in_busy;
    assign err_tmo           = 1'b0;
`endif

    // Request capture, arbitration and transfer sequencing.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        cmd_d        = cmd_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rd_data_d    = rd_data_q;
        done_d       = 2'b00;
        err_ovr_d    = err_ovr_q;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_hit      = 1'b0;
`endif

        // A requester with work pending or in flight cannot queue a second one.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_v[i]) begin
                if (!pend_q[i] && !((state_q != IDLE) && (owner_q == req_id_t'(i)))) begin
                    pend_d[i] = 1'b1;
                    cmd_d[i]  = cmd_in[i];
                end else begin
                    err_ovr_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    owner_d         = rr_pick(pend_q, last_owner_q);
                    pend_d[owner_d] = 1'b0;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (mstr_done) begin
                    rd_data_d       = mstr_rd;
                    done_d[owner_q] = 1'b1;
                    last_owner_d    = owner_q;
                    state_d         = IDLE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_expire) begin
                    rd_data_d       = TMO_DATA;
                    done_d[owner_q] = 1'b1;
                    last_owner_d    = owner_q;
                    tmo_hit         = 1'b1;
                    state_d         = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_q       <= 2'b00;
            cmd_q[0]     <= 16'h0000;
            cmd_q[1]     <= 16'h0000;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            rd_data_q    <= 16'h0000;
            done_q       <= 2'b00;
            err_ovr_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            cmd_q[0]     <= cmd_d[0];
            cmd_q[1]     <= cmd_d[1];
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
            err_ovr_q    <= err_ovr_d;
        end
    end

    assign done0    = done_q[0];
    assign done1    = done_q[1];
    assign rd_data  = rd_data_q;
    assign err_ovr  = err_ovr_q;
    assign mstr_wrt = (state_q == ISSUE);
    assign mstr_cmd = (state_q == IDLE) ? 16'h0000 : cmd_q[owner_q];

    // Only the owner's slave sees the master's select, and only while a transfer is active.
    assign ss0_n = mstr_ss_n | (owner_q != 1'b0) | (state_q == IDLE);
    assign ss1_n = mstr_ss_n | (owner_q != 1'b1) | (state_q == IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter (build with or without SPI_ARB_TIMEOUT_EN).
module tb_spi_bus_arbiter;

  localparam int CLK_HALF = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #CLK_HALF clk = ~clk;

  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] cmd0 = 16'h0;
  logic [15:0] cmd1 = 16'h0;
  logic        done0, done1;
  logic [15:0] rd_data;
  logic        mstr_wrt;
  logic [15:0] mstr_cmd;
  logic        mstr_done = 1'b0;
  logic [15:0] mstr_rd   = 16'h0;
  logic        mstr_ss_n = 1'b1;
  logic        ss0_n, ss1_n;
  logic [1:0]  err_ovr;
  logic        err_tmo;

  int checks = 0;
  int errors = 0;

  // scoreboard: {owner, cmd, expected rd_data} in expected grant order
  logic [32:0] exp_q[$];
  logic [32:0] cur = '0;
  logic        have_cur = 1'b0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  // SPI master model controls
  logic        slv_hang  = 1'b0;
  logic        slv_fixed = 1'b0;
  logic [15:0] slv_rd    = 16'h0;
  logic        slv_act   = 1'b0;
  logic [15:0] slv_cmd   = 16'h0;
  int          slv_cnt   = 0;

  spi_bus_arbiter #(.TMO_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .cmd0     (cmd0),
    .cmd1     (cmd1),
    .done0    (done0),
    .done1    (done1),
    .rd_data  (rd_data),
    .mstr_wrt (mstr_wrt),
    .mstr_cmd (mstr_cmd),
    .mstr_done(mstr_done),
    .mstr_rd  (mstr_rd),
    .mstr_ss_n(mstr_ss_n),
    .ss0_n    (ss0_n),
    .ss1_n    (ss1_n),
    .err_ovr  (err_ovr),
    .err_tmo  (err_tmo)
  );

  // SPI_mstr16 stand-in: starts on mstr_wrt, holds SS_n low a few cycles, answers cmd^5A5A
  always @(negedge clk) begin
    if (rst) begin
      slv_act   = 1'b0;
      mstr_done = 1'b0;
      mstr_ss_n = 1'b1;
    end else begin
      mstr_done = 1'b0;
      if (slv_act) begin
        if (slv_cnt == 0) begin
          if (!slv_hang) begin
            mstr_done = 1'b1;
            mstr_rd   = slv_fixed ? slv_rd : (slv_cmd ^ 16'h5A5A);
            mstr_ss_n = 1'b1;
            slv_act   = 1'b0;
          end
        end else begin
          slv_cnt = slv_cnt - 1;
        end
      end else if (mstr_wrt) begin
        slv_act   = 1'b1;
        slv_cmd   = mstr_cmd;
        slv_cnt   = $urandom_range(0, 3);
        mstr_ss_n = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    slv_hang = 1'b0;
    slv_fixed = 1'b0;
    have_cur = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Consume scoreboard entries: mstr_wrt pops the next expected grant, done must match it.
  task automatic run_scoreboard(input int budget);
    int n;
    logic [1:0] exp_ss;
    logic [1:0] exp_done;
    n = 0;
    forever begin
      if (mstr_wrt) begin
        checks++;
        if (exp_q.size() == 0 || have_cur) begin
          errors++;
          $display("FAIL sb_wrt: unexpected mstr_wrt cmd=%h", mstr_cmd);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          if (mstr_cmd !== cur[31:16]) begin
            errors++;
            $display("FAIL sb_cmd: mstr_cmd=%h expected %h", mstr_cmd, cur[31:16]);
          end
        end
      end else if (have_cur && mstr_ss_n == 1'b0) begin
        checks++;
        exp_ss = cur[32] ? 2'b01 : 2'b10;
        if ({ss1_n, ss0_n} !== exp_ss) begin
          errors++;
          $display("FAIL sb_ss: {ss1_n,ss0_n}=%b expected %b", {ss1_n, ss0_n}, exp_ss);
        end
      end
      if (done0 || done1) begin
        checks++;
        exp_done = cur[32] ? 2'b10 : 2'b01;
        if (!have_cur) begin
          errors++;
          $display("FAIL sb_done: unexpected done {done1,done0}=%b", {done1, done0});
        end else if ({done1, done0, rd_data} !== {exp_done, cur[15:0]}) begin
          errors++;
          $display("FAIL sb_done: done=%b rd_data=%h expected done=%b rd_data=%h",
                   {done1, done0}, rd_data, exp_done, cur[15:0]);
        end
        have_cur = 1'b0;
      end
      if (exp_q.size() == 0 && !have_cur) break;
      if (n >= budget) break;
      tick();
      n++;
    end
    if (exp_q.size() != 0 || have_cur) begin
      checks++;
      errors++;
      $display("FAIL sb_timeout: %0d grants outstanding (in flight=%0b) expected 0", exp_q.size(), have_cur);
      exp_q.delete();
      have_cur = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [39:0] got;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    got = {done1, done0, rd_data, mstr_wrt, mstr_cmd, ss1_n, ss0_n, err_ovr, err_tmo};
    if (got !== {2'b00, 16'h0000, 1'b0, 16'h0000, 2'b11, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", got,
               {2'b00, 16'h0000, 1'b0, 16'h0000, 2'b11, 2'b00, 1'b0});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({mstr_wrt, ss1_n, ss0_n, done1, done0} !== 5'b01100) begin
      errors++;
      $display("FAIL reset_idle: {wrt,ss1,ss0,d1,d0}=%b expected 01100", {mstr_wrt, ss1_n, ss0_n, done1, done0});
    end
  endtask

  task automatic test_single();
    int n;
    slv_fixed = 1'b1;
    slv_rd = 16'h00C5;
    cmd0 = 16'hA200;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    checks++;
    if (mstr_wrt !== 1'b0) begin
      errors++;
      $display("FAIL single_early: mstr_wrt=%b expected 0", mstr_wrt);
    end
    tick();
    checks++;
    if ({mstr_wrt, mstr_cmd} !== {1'b1, 16'hA200}) begin
      errors++;
      $display("FAIL single_issue: wrt=%b cmd=%h expected 1 a200", mstr_wrt, mstr_cmd);
    end
    tick();
    checks++;
    if ({mstr_wrt, mstr_cmd, ss1_n, ss0_n} !== {1'b0, 16'hA200, 2'b10}) begin
      errors++;
      $display("FAIL single_busy: wrt=%b cmd=%h ss1=%b ss0=%b expected 0 a200 1 0",
               mstr_wrt, mstr_cmd, ss1_n, ss0_n);
    end
    n = 0;
    while (!(done0 || done1) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if ({done1, done0, rd_data} !== {2'b01, 16'h00C5}) begin
      errors++;
      $display("FAIL single_done: done=%b rd_data=%h expected 01 00c5", {done1, done0}, rd_data);
    end
    tick();
    checks++;
    if ({done1, done0, mstr_cmd, ss1_n, ss0_n} !== {2'b00, 16'h0000, 2'b11}) begin
      errors++;
      $display("FAIL single_after: done=%b cmd=%h ss=%b expected 00 0000 11",
               {done1, done0}, mstr_cmd, {ss1_n, ss0_n});
    end
    slv_fixed = 1'b0;
  endtask

  task automatic test_contention();
    logic [15:0] c0, c1;
    reset_dut();
    for (int p = 0; p < 2; p++) begin
      c0 = 16'($urandom_range(0, 65535));
      c1 = 16'($urandom_range(0, 65535));
      cmd0 = c0;
      cmd1 = c1;
      req0 = 1'b1;
      req1 = 1'b1;
      exp_q.push_back({1'b0, c0, c0 ^ 16'h5A5A});
      exp_q.push_back({1'b1, c1, c1 ^ 16'h5A5A});
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      run_scoreboard(200);
    end
    checks++;
    if (err_ovr !== 2'b00) begin
      errors++;
      $display("FAIL contention_ovr: err_ovr=%b expected 00", err_ovr);
    end
  endtask

  task automatic test_overrun();
    reset_dut();
    cmd0 = 16'h0555;
    cmd1 = 16'h1111;
    req0 = 1'b1;
    req1 = 1'b1;
    exp_q.push_back({1'b0, 16'h0555, 16'h0555 ^ 16'h5A5A});
    exp_q.push_back({1'b1, 16'h1111, 16'h1111 ^ 16'h5A5A});
    tick();
    req0 = 1'b0;
    cmd1 = 16'h2222;
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    checks++;
    if (err_ovr !== 2'b10) begin
      errors++;
      $display("FAIL overrun_flag: err_ovr=%b expected 10", err_ovr);
    end
    run_scoreboard(200);
    checks++;
    if (err_ovr !== 2'b10) begin
      errors++;
      $display("FAIL overrun_sticky: err_ovr=%b expected 10", err_ovr);
    end
  endtask

  // Runs straight after test_overrun so the mid-transfer reset must also clear err_ovr.
  task automatic test_reset_mid();
    logic [39:0] got;
    logic seen_done;
    slv_hang = 1'b1;
    cmd0 = 16'h7777;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    checks++;
    if ({mstr_cmd, ss0_n} !== {16'h7777, 1'b0}) begin
      errors++;
      $display("FAIL rmid_busy: cmd=%h ss0=%b expected 7777 0", mstr_cmd, ss0_n);
    end
    rst = 1'b1;
    #1;
    checks++;
    got = {done1, done0, rd_data, mstr_wrt, mstr_cmd, ss1_n, ss0_n, err_ovr, err_tmo};
    if (got !== {2'b00, 16'h0000, 1'b0, 16'h0000, 2'b11, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL rmid_outputs: got %h expected %h", got,
               {2'b00, 16'h0000, 1'b0, 16'h0000, 2'b11, 2'b00, 1'b0});
    end
    seen_done = 1'b0;
    repeat (3) begin
      tick();
      seen_done = seen_done | done0 | done1;
    end
    rst = 1'b0;
    slv_hang = 1'b0;
    repeat (3) begin
      tick();
      seen_done = seen_done | done0 | done1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL rmid_nodone: done pulse seen=%b expected 0", seen_done);
    end
    cmd0 = 16'h0BCD;
    req0 = 1'b1;
    exp_q.push_back({1'b0, 16'h0BCD, 16'h0BCD ^ 16'h5A5A});
    tick();
    req0 = 1'b0;
    run_scoreboard(100);
  endtask

  task automatic test_timeout();
`ifdef SPI_ARB_TIMEOUT_EN
    int busy_n;
    reset_dut();
    slv_hang = 1'b1;
    cmd0 = 16'h0C0C;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    busy_n = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done0 || done1) break;
      busy_n++;
    end
    checks++;
    if (busy_n != 16) begin
      errors++;
      $display("FAIL tmo_cycles: busy cycles=%0d expected 16", busy_n);
    end
    checks++;
    if ({done1, done0, rd_data, err_tmo} !== {2'b01, 16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL tmo_done: done=%b rd_data=%h err_tmo=%b expected 01 ffff 1",
               {done1, done0}, rd_data, err_tmo);
    end
    tick();
    checks++;
    if ({done0, err_tmo, mstr_cmd} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL tmo_after: done0=%b err_tmo=%b cmd=%h expected 0 1 0000", done0, err_tmo, mstr_cmd);
    end
    reset_dut();
`else
    logic seen_done;
    reset_dut();
    slv_hang = 1'b1;
    cmd0 = 16'h0C0C;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    seen_done = 1'b0;
    repeat (42) begin
      tick();
      seen_done = seen_done | done0 | done1;
    end
    checks++;
    if ({seen_done, err_tmo, mstr_cmd} !== {1'b0, 1'b0, 16'h0C0C}) begin
      errors++;
      $display("FAIL notmo_wait: done seen=%b err_tmo=%b cmd=%h expected 0 0 0c0c",
               seen_done, err_tmo, mstr_cmd);
    end
    reset_dut();
`endif
  endtask

  task automatic test_back_to_back();
    logic nxt;
    int dones;
    int issued0, issued1;
    logic out0, out1;
    logic [15:0] c, e;
    reset_dut();
    nxt = 1'b0;
    dones = 0;
    issued0 = 0;
    issued1 = 0;
    out0 = 1'b0;
    out1 = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    for (int cyc = 0; cyc < 3000 && dones < 20; cyc++) begin
      req0 = 1'b0;
      req1 = 1'b0;
      if (done0 || done1) begin
        checks++;
        if (done0 && done1) begin
          errors++;
          $display("FAIL b2b_two_dones: done=%b expected one-hot", {done1, done0});
        end else if (done1 !== nxt) begin
          errors++;
          $display("FAIL b2b_order: owner=%0d expected %0d", done1, nxt);
        end else if ((done1 ? exp_q1.size() : exp_q0.size()) == 0) begin
          errors++;
          $display("FAIL b2b_extra: done for requester %0d with nothing outstanding", done1);
        end else begin
          if (done1) begin
            e = exp_q1.pop_front();
            out1 = 1'b0;
          end else begin
            e = exp_q0.pop_front();
            out0 = 1'b0;
          end
          checks++;
          if (rd_data !== (e ^ 16'h5A5A)) begin
            errors++;
            $display("FAIL b2b_data: rd_data=%h expected %h", rd_data, e ^ 16'h5A5A);
          end
        end
        nxt = ~nxt;
        dones++;
      end
      if (!out0 && issued0 < 10) begin
        c = 16'($urandom_range(0, 65535));
        cmd0 = c;
        req0 = 1'b1;
        exp_q0.push_back(c);
        out0 = 1'b1;
        issued0++;
      end
      if (!out1 && issued1 < 10) begin
        c = 16'($urandom_range(0, 65535));
        cmd1 = c;
        req1 = 1'b1;
        exp_q1.push_back(c);
        out1 = 1'b1;
        issued1++;
      end
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checks++;
    if (dones != 20 || err_ovr !== 2'b00) begin
      errors++;
      $display("FAIL b2b_count: dones=%0d err_ovr=%b expected 20 00", dones, err_ovr);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_overrun();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
